// File: rtl/time_set_ctrl.sv
// Time/date setting controller: mode FSM, edge-detected up/down strobes with
// auto-repeat, idle timeout back to RUN, and blink for the field being edited.
module time_set_ctrl #(
   parameter int TIMEOUT    = 30,
   parameter int REPEAT_DLY = 2
) (
   input  logic       clk_1Hz,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [2:0] select_item,
   output logic       en_1,
   output logic       up,
   output logic       down,
   output logic       sec_clr,
   output logic       blink
);

   typedef enum logic [2:0] {
      RUN      = 3'b000,
      SET_MIN  = 3'b001,
      SET_HOUR = 3'b010,
      SET_DAY  = 3'b011,
      SET_MON  = 3'b100,
      SET_YEAR = 3'b101
   } state_t;

   localparam logic [3:0] LP_RPT     = 4'(REPEAT_DLY);
   localparam logic [5:0] LP_TO_LAST = 6'(TIMEOUT - 1);

   state_t     r_state;
   state_t     w_state_next;
   logic       r_mode_d, r_up_d, r_down_d;
   logic [3:0] r_hold, w_hold_next;
   logic [5:0] r_idle, w_idle_next;
   logic       r_up, r_down, r_sec_clr, r_blink, r_en_1;
   logic       w_up_next, w_down_next, w_sec_clr_next, w_blink_next, w_en_1_next;

   logic w_mode_edge, w_up_edge, w_down_edge, w_any_edge;
   logic w_single, w_repeat, w_up_req, w_down_req, w_activity, w_in_set;

   assign w_mode_edge = btn_mode & ~r_mode_d;
   assign w_up_edge   = btn_up   & ~r_up_d;
   assign w_down_edge = btn_down & ~r_down_d;
   assign w_any_edge  = w_mode_edge | w_up_edge | w_down_edge;

   // Exactly one of up/down held; pressing both cancels strobes and the hold count.
   assign w_single   = btn_up ^ btn_down;
   assign w_repeat   = w_single & (r_hold >= LP_RPT);
   assign w_up_req   = btn_up   & ~btn_down & (w_up_edge   | w_repeat);
   assign w_down_req = btn_down & ~btn_up   & (w_down_edge | w_repeat);
   assign w_activity = w_any_edge | w_up_req | w_down_req;
   assign w_in_set   = (r_state != RUN);

   always_ff @(posedge clk_1Hz or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_mode_edge) begin
         case (r_state)
            RUN:      w_state_next = SET_MIN;
            SET_MIN:  w_state_next = SET_HOUR;
            SET_HOUR: w_state_next = SET_DAY;
            SET_DAY:  w_state_next = SET_MON;
            SET_MON:  w_state_next = SET_YEAR;
            SET_YEAR: w_state_next = RUN;
            default:  w_state_next = RUN;
         endcase
      end else if (w_in_set && !w_activity && (r_idle >= LP_TO_LAST)) begin
         w_state_next = RUN;
      end
   end

   always_comb begin
      w_hold_next = r_hold;
      if (!w_single) begin
         w_hold_next = 4'd0;
      end else if (w_up_edge || w_down_edge) begin
         // A new press of the held button restarts the repeat delay.
         w_hold_next = 4'd1;
      end else if (r_hold != 4'hF) begin
         w_hold_next = r_hold + 4'd1;
      end
   end

   always_comb begin
      w_idle_next = r_idle + 6'd1;
      if (!w_in_set || (w_state_next != r_state) || w_activity) begin
         w_idle_next = 6'd0;
      end
   end

   always_comb begin
      w_up_next      = 1'b0;
      w_down_next    = 1'b0;
      w_sec_clr_next = 1'b0;
      w_en_1_next    = (w_state_next == RUN);
      w_blink_next   = 1'b0;
      // Strobes only while staying in the same SET state; mode edges win.
      if (w_in_set && !w_mode_edge && (w_state_next == r_state)) begin
         w_up_next   = w_up_req;
         w_down_next = w_down_req;
      end
      if (w_in_set && (w_state_next == RUN)) begin
         w_sec_clr_next = 1'b1;
      end
      if (w_state_next != RUN) begin
         w_blink_next = (w_state_next != r_state) ? 1'b1 : ~r_blink;
      end
   end

   always_ff @(posedge clk_1Hz or negedge rst_n) begin
      if (!rst_n) begin
         r_mode_d  <= 1'b0;
         r_up_d    <= 1'b0;
         r_down_d  <= 1'b0;
         r_hold    <= 4'd0;
         r_idle    <= 6'd0;
         r_up      <= 1'b0;
         r_down    <= 1'b0;
         r_sec_clr <= 1'b0;
         r_blink   <= 1'b0;
         r_en_1    <= 1'b1;
      end else begin
         r_mode_d  <= btn_mode;
         r_up_d    <= btn_up;
         r_down_d  <= btn_down;
         r_hold    <= w_hold_next;
         r_idle    <= w_idle_next;
         r_up      <= w_up_next;
         r_down    <= w_down_next;
         r_sec_clr <= w_sec_clr_next;
         r_blink   <= w_blink_next;
         r_en_1    <= w_en_1_next;
      end
   end

   assign select_item = r_state;
   assign en_1        = r_en_1;
   assign up          = r_up;
   assign down        = r_down;
   assign sec_clr     = r_sec_clr;
   assign blink       = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl; observed vector is
// {select_item, en_1, up, down, sec_clr, blink}.
module tb_time_set_ctrl;

   logic       clk_1Hz = 1'b0;
   logic       rst_n   = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up   = 1'b0;
   logic       btn_down = 1'b0;
   logic [2:0] select_item;
   logic       en_1, up, down, sec_clr, blink;
   logic [7:0] obs;

   int n_tests = 0;
   int n_fail  = 0;

   time_set_ctrl #(.TIMEOUT(30), .REPEAT_DLY(2)) dut (
      .clk_1Hz     (clk_1Hz),
      .rst_n       (rst_n),
      .btn_mode    (btn_mode),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .select_item (select_item),
      .en_1        (en_1),
      .up          (up),
      .down        (down),
      .sec_clr     (sec_clr),
      .blink       (blink)
   );

   assign obs = {select_item, en_1, up, down, sec_clr, blink};

   initial forever #5 clk_1Hz = ~clk_1Hz;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired, required finish");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk_1Hz);
      #1;
   endtask

   task automatic do_reset;
      btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic press_mode(input int n);
      for (int i = 0; i < n; i++) begin
         btn_mode = 1'b1; step();
         btn_mode = 1'b0; step();
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      step(); step();
      n_tests++;
      if (obs !== 8'b000_10000) begin
         n_fail++; $display("FAIL reset_hold: got %b expected %b", obs, 8'b000_10000);
      end
      rst_n = 1'b1;
      step();
      n_tests++;
      if (obs !== 8'b000_10000) begin
         n_fail++; $display("FAIL reset_release: got %b expected %b", obs, 8'b000_10000);
      end
      // Held up/down buttons must not strobe in RUN, even past the repeat delay.
      btn_up = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         n_tests++;
         if (obs !== 8'b000_10000) begin
            n_fail++; $display("FAIL run_up_ignored[%0d]: got %b expected %b", k, obs, 8'b000_10000);
         end
      end
      btn_up = 1'b0; btn_down = 1'b1;
      step();
      n_tests++;
      if (obs !== 8'b000_10000) begin
         n_fail++; $display("FAIL run_down_ignored: got %b expected %b", obs, 8'b000_10000);
      end
      btn_down = 1'b0;
      step();
      $display("[TB] test_reset done");
   endtask

   task automatic test_mode_seq;
      logic [7:0] exp_tab [0:11];
      exp_tab = '{8'b001_00001, 8'b001_00000, 8'b010_00001, 8'b010_00000,
                  8'b011_00001, 8'b011_00000, 8'b100_00001, 8'b100_00000,
                  8'b101_00001, 8'b101_00000, 8'b000_10010, 8'b000_10000};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         btn_mode = 1'b1; step();
         n_tests++;
         if (obs !== exp_tab[2*i]) begin
            n_fail++; $display("FAIL mode_press[%0d]: got %b expected %b", i, obs, exp_tab[2*i]);
         end
         btn_mode = 1'b0; step();
         n_tests++;
         if (obs !== exp_tab[2*i+1]) begin
            n_fail++; $display("FAIL mode_release[%0d]: got %b expected %b", i, obs, exp_tab[2*i+1]);
         end
      end
      $display("[TB] test_mode_seq done");
   endtask

   task automatic test_repeat;
      logic [7:0] exp_tab [0:5];
      exp_tab = '{8'b001_01001, 8'b001_00000, 8'b001_01001,
                  8'b001_01000, 8'b001_01001, 8'b001_01000};
      do_reset();
      press_mode(1);
      btn_up = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         n_tests++;
         if (obs !== exp_tab[c]) begin
            n_fail++; $display("FAIL repeat_cycle%0d: got %b expected %b", c + 1, obs, exp_tab[c]);
         end
      end
      btn_up = 1'b0;
      step();
      n_tests++;
      if (obs !== 8'b001_00001) begin
         n_fail++; $display("FAIL repeat_release: got %b expected %b", obs, 8'b001_00001);
      end
      step();
      btn_down = 1'b1;
      step();
      n_tests++;
      if (obs !== 8'b001_00101) begin
         n_fail++; $display("FAIL down_pulse: got %b expected %b", obs, 8'b001_00101);
      end
      btn_down = 1'b0;
      step();
      n_tests++;
      if (obs !== 8'b001_00000) begin
         n_fail++; $display("FAIL down_release: got %b expected %b", obs, 8'b001_00000);
      end
      $display("[TB] test_repeat done");
   endtask

   task automatic test_conflict;
      do_reset();
      press_mode(2);
      btn_up = 1'b1; btn_down = 1'b1;
      step();
      n_tests++;
      if (obs !== 8'b010_00001) begin
         n_fail++; $display("FAIL both_rise: got %b expected %b", obs, 8'b010_00001);
      end
      step(); step(); step();
      n_tests++;
      if (obs !== 8'b010_00000) begin
         n_fail++; $display("FAIL both_held: got %b expected %b", obs, 8'b010_00000);
      end
      btn_up = 1'b0; btn_down = 1'b0;
      step();
      btn_mode = 1'b1; btn_up = 1'b1;
      step();
      n_tests++;
      if (obs !== 8'b011_00001) begin
         n_fail++; $display("FAIL mode_up_together: got %b expected %b", obs, 8'b011_00001);
      end
      btn_mode = 1'b0; btn_up = 1'b0;
      step();
      n_tests++;
      if (obs !== 8'b011_00000) begin
         n_fail++; $display("FAIL mode_up_after: got %b expected %b", obs, 8'b011_00000);
      end
      $display("[TB] test_conflict done");
   endtask

   task automatic test_timeout;
      // Plain timeout: 30 cycles in SET_DAY, then RUN with one sec_clr.
      do_reset();
      press_mode(2);
      btn_mode = 1'b1; step(); btn_mode = 1'b0;
      for (int k = 1; k <= 29; k++) begin
         step();
         n_tests++;
         if ({select_item, en_1} !== 4'b011_0) begin
            n_fail++; $display("FAIL timeout_wait[%0d]: got %b expected %b", k, {select_item, en_1}, 4'b011_0);
         end
      end
      step();
      n_tests++;
      if (obs !== 8'b000_10010) begin
         n_fail++; $display("FAIL timeout_exit: got %b expected %b", obs, 8'b000_10010);
      end
      step();
      n_tests++;
      if (obs !== 8'b000_10000) begin
         n_fail++; $display("FAIL timeout_after: got %b expected %b", obs, 8'b000_10000);
      end
      // Restart: an up press sampled on cycle 29 delays the exit by 29 cycles.
      do_reset();
      press_mode(2);
      btn_mode = 1'b1; step(); btn_mode = 1'b0;
      for (int k = 1; k <= 28; k++) step();
      btn_up = 1'b1;
      step();
      n_tests++;
      if (obs[7:1] !== 7'b011_0100) begin
         n_fail++; $display("FAIL restart_press: got %b expected %b", obs[7:1], 7'b011_0100);
      end
      btn_up = 1'b0;
      for (int k = 30; k <= 58; k++) begin
         step();
         n_tests++;
         if (obs[7:1] !== 7'b011_0000) begin
            n_fail++; $display("FAIL restart_wait[%0d]: got %b expected %b", k, obs[7:1], 7'b011_0000);
         end
      end
      step();
      n_tests++;
      if (obs !== 8'b000_10010) begin
         n_fail++; $display("FAIL restart_exit: got %b expected %b", obs, 8'b000_10010);
      end
      $display("[TB] test_timeout done");
   endtask

   task automatic test_reset_mid_edit;
      do_reset();
      press_mode(5);
      n_tests++;
      if (select_item !== 3'b101) begin
         n_fail++; $display("FAIL mid_edit_state: got %b expected %b", select_item, 3'b101);
      end
      btn_up = 1'b1;
      step(); step(); step();
      n_tests++;
      if (obs[7:4] !== 4'b101_0 || up !== 1'b1) begin
         n_fail++; $display("FAIL mid_edit_repeat: got %b expected sel/en 1010 with up=1", obs);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (obs !== 8'b000_10000) begin
         n_fail++; $display("FAIL mid_edit_async: got %b expected %b", obs, 8'b000_10000);
      end
      step();
      n_tests++;
      if (obs !== 8'b000_10000) begin
         n_fail++; $display("FAIL mid_edit_in_reset: got %b expected %b", obs, 8'b000_10000);
      end
      rst_n = 1'b1;
      step();
      n_tests++;
      if (obs !== 8'b000_10000) begin
         n_fail++; $display("FAIL mid_edit_release: got %b expected %b", obs, 8'b000_10000);
      end
      step();
      n_tests++;
      if (obs !== 8'b000_10000) begin
         n_fail++; $display("FAIL mid_edit_run: got %b expected %b", obs, 8'b000_10000);
      end
      btn_up = 1'b0;
      $display("[TB] test_reset_mid_edit done");
   endtask

   initial begin
      test_reset();
      test_mode_seq();
      test_repeat();
      test_conflict();
      test_timeout();
      test_reset_mid_edit();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
